// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan controller.
//   SEG_BLANK  : active-low segment pattern with every segment off
//   ANODE_OFF  : active-low anode pattern with every digit off (sliced to NUM_DIGITS)
//   scan_state_t : slot state, ST_BLANK (guard cycles) / ST_DRIVE (digit lit)
package seven_seg_scan_ctrl_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_hex2seg.sv
// hexToSevenSeg: hex nibble to active-low seven-segment pattern.
// Ports:
//   hex : input  [3:0] nibble to decode
//   seg : output [6:0] active-low segments, seg[0]=a .. seg[6]=g
module hexToSevenSeg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// multi-digit seven-segment display, one shared hex decoder.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   value      : [4*NUM_DIGITS-1:0] hex value, nibble i -> digit i
//   load       : one-cycle strobe, captures value into the shadow register
//   digit_en   : [NUM_DIGITS-1:0] per-digit enable (0 = dark for its slot)
//   anode      : [NUM_DIGITS-1:0] active-low digit select, registered
//   sevenSeg   : [6:0] active-low segments, registered
//   frame_tick : high in the first cycle of digit 0's slot
// Optional build macro: LEADING_ZERO_BLANK_EN darkens leading zero digits
// (digit 0 always shown).
// Handshake: load is a plain strobe, no ready; a new value is shown from the
// next frame boundary after its last load, so a frame never mixes two values.
module seven_seg_scan_ctrl
  import seven_seg_scan_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              sevenSeg,
  output logic                    frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = ANODE_OFF[NUM_DIGITS-1:0];

  logic [CW-1:0]           cnt, cnt_n;
  logic [IW-1:0]           idx, idx_n;
  scan_state_t             state, state_n;
  logic [4*NUM_DIGITS-1:0] shadow, disp_val;
  logic                    pending;
  logic                    cnt_wrap, frame_end;
  logic [NUM_DIGITS-1:0]   anode_n;
  logic [6:0]              seg_n;
  logic [3:0]              dec_nibble;
  logic [6:0]              dec_seg;
  logic                    show_digit;

  // Single shared decoder, fed with the digit about to be driven.
  assign dec_nibble = disp_val[idx_n*4 +: 4];

  hexToSevenSeg u_dec (
    .hex (dec_nibble),
    .seg (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // lit[i] is set when digit i or any more significant digit is non-zero.
  logic [NUM_DIGITS-1:0] lit;
  logic                  nz_above;
  always_comb begin
    lit      = '0;
    nz_above = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nz_above = nz_above | (disp_val[i*4 +: 4] != 4'h0);
      lit[i]   = (i == 0) | nz_above;
    end
  end
  assign show_digit = lit[idx_n];
`else
  assign show_digit = 1'b1;
`endif

  assign cnt_wrap  = (cnt == CNT_LAST);
  assign frame_end = cnt_wrap && (idx == IDX_LAST);

  // Gated by reset so the pulse is absent while reset is held, yet present in
  // the very first cycle after release (cnt and idx are already 0 then).
  assign frame_tick = !reset && (cnt == '0) && (idx == '0);

  always_comb begin
    cnt_n   = cnt_wrap ? '0 : cnt + 1'b1;
    idx_n   = idx;
    state_n = state;
    anode_n = AN_OFF;
    seg_n   = SEG_BLANK;
    if (cnt_wrap) begin
      idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
    case (state)
      ST_BLANK: if (cnt_n == BLANK_END) state_n = ST_DRIVE;
      ST_DRIVE: if (cnt_wrap)           state_n = ST_BLANK;
      default:                          state_n = ST_BLANK;
    endcase
    // Outputs follow the next state so they move on the same edge as it.
    if (state_n == ST_DRIVE && digit_en[idx_n] && show_digit) begin
      anode_n[idx_n] = 1'b0;
      seg_n          = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      idx      <= '0;
      state    <= ST_BLANK;
      anode    <= AN_OFF;
      sevenSeg <= SEG_BLANK;
      shadow   <= '0;
      disp_val <= '0;
      pending  <= 1'b0;
    end else begin
      cnt      <= cnt_n;
      idx      <= idx_n;
      state    <= state_n;
      anode    <= anode_n;
      sevenSeg <= seg_n;
      if (frame_end && pending) begin
        disp_val <= shadow;
      end
      // A load on the boundary edge lands in shadow and waits a full frame.
      if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end else if (frame_end) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int FRAME = ND * RD;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*ND-1:0] value;
  logic          load;
  logic [ND-1:0] digit_en;
  logic [ND-1:0] anode;
  logic [6:0]    sevenSeg;
  logic          frame_tick;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .value      (value),
    .load       (load),
    .digit_en   (digit_en),
    .anode      (anode),
    .sevenSeg   (sevenSeg),
    .frame_tick (frame_tick)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model state: position inside the frame, display contents
  int            p;
  logic [15:0]   m_disp, m_shadow;
  bit            m_pend;
  logic [ND-1:0] en_prev;
  logic [6:0]    seg_tab [16];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic bit digit_lit(input int d);
`ifdef LEADING_ZERO_BLANK_EN
    return (d == 0) || ((m_disp >> (4 * d)) != 16'h0);
`else
    return (d >= 0);
`endif
  endfunction

  // Compare the current cycle against the model, then advance the model over
  // the coming edge and return #1 after that edge for the driver.
  task automatic step();
    int d, c;
    logic [ND-1:0] exp_an;
    logic [6:0]    exp_seg;
    @(negedge clk);
    d = p / RD;
    c = p % RD;
    exp_an  = '1;
    exp_seg = 7'h7F;
    if (c >= BC && en_prev[d] && digit_lit(d)) begin
      exp_an[d] = 1'b0;
      exp_seg   = seg_tab[(m_disp >> (4 * d)) & 16'hF];
    end
    chk("anode", anode, exp_an);
    chk("sevenSeg", sevenSeg, exp_seg);
    chk("frame_tick", frame_tick, (p == 0 && !reset));
    if (reset) begin
      p = 0; m_disp = 0; m_shadow = 0; m_pend = 0;
    end else begin
      if (p == FRAME - 1 && m_pend) begin
        m_disp = m_shadow;
        m_pend = 0;
      end
      if (load) begin
        m_shadow = value;
        m_pend   = 1;
      end
      p = (p + 1) % FRAME;
    end
    en_prev = digit_en;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int target);
    int k = 0;
    while (p != target && k < FRAME) begin
      step();
      k++;
    end
    chk("reach_pos", p, target);
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    run(n);
    reset = 1'b0;
  endtask

  initial begin
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    p = 0; m_disp = 0; m_shadow = 0; m_pend = 0; en_prev = '1;
    reset = 1'b1; load = 1'b0; value = '0; digit_en = '1;
    @(posedge clk);
    #1;
    do_reset(2);
    chk("rst_anode", anode, 4'hF);
    chk("rst_seg", sevenSeg, 7'h7F);

    // display 1234, then free-run
    do_load(16'h1234);
    run(3 * FRAME);
    // load mid-frame at cnt=3 of digit 1: held until the next boundary
    run_until(RD + 3);
    do_load(16'hABCD);
    run(2 * FRAME);
    // disabled digits keep their slot dark
    digit_en = 4'b0101;
    run(2 * FRAME);
    digit_en = 4'b1111;
    // reset at cnt=5 of digit 2 discards pending data
    do_load(16'h5A5A);
    run_until(2 * RD + 5);
    do_reset(1);
    run(2 * FRAME);
    // leading zeros
    do_load(16'h0040);
    run(2 * FRAME);
    // load on the frame boundary edge waits a full frame
    run_until(FRAME - 1);
    do_load(16'h9E07);
    run(2 * FRAME);
    // several loads in one frame: last one wins
    do_load(16'h1111);
    do_load(16'h2222);
    do_load(16'h0003);
    run(2 * FRAME);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        value = 16'($urandom);
        if ($urandom_range(0, 3) == 0) value[15:8] = 8'h00;
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) digit_en = 4'($urandom);
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;
    load  = 1'b0;
    run(FRAME);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It holds a NUM_DIGITS-nibble display value and shares a single hex-to-seven-segment decoder across all digits. It cycles digit slots at a fixed refresh rate and inserts blanking guard cycles between slots to suppress ghosting. It sits between datapath logic that produces a hex value and the board's anode and segment pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
REFRESH_DIV, 50000, clock cycles per digit slot; must be > BLANK_CYCLES
BLANK_CYCLES, 4, cycles at the start of each slot with all anodes off; must be >= 1

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
value  input  4*NUM_DIGITS  hex value to display; nibble i drives digit i, digit 0 is least significant
load  input  1  one-cycle strobe that captures value into the shadow register
digit_en  input  NUM_DIGITS  per-digit enable; 0 keeps that digit dark for its slot
anode  output  NUM_DIGITS  active-low digit select, registered
sevenSeg  output  7  active-low segments, seg[0]=a .. seg[6]=g, registered
frame_tick  output  1  one-cycle pulse on the first cycle of each frame

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high; it takes effect on the next rising edge only.
- Reset values: anode all 1s, sevenSeg 7'b1111111, frame_tick 0, slot counter 0, digit index 0, state BLANK, shadow 0, disp_val 0, pending 0.
- Slot counter cnt:
  - Width $clog2(REFRESH_DIV); counts 0..REFRESH_DIV-1.
  - Wraps to 0 after REFRESH_DIV-1 and increments the digit index on that wrap.
  - Digit index wraps from NUM_DIGITS-1 to 0.
- State machine (2 states):
  - BLANK while cnt < BLANK_CYCLES.
  - DRIVE while cnt >= BLANK_CYCLES.
  - BLANK -> DRIVE when cnt reaches BLANK_CYCLES.
  - DRIVE -> BLANK on slot wrap.
- Outputs are registered from next-state values, so anode and sevenSeg change on the same edge as the state, with no extra latency.
- BLANK: anode all 1s, sevenSeg 7'b1111111.
- DRIVE, digit i:
  - If digit_en[i]=1: anode has bit i=0 and all others 1; sevenSeg = decode(disp_val nibble i).
  - If digit_en[i]=0: anode all 1s, sevenSeg all 1s, and the slot still consumes REFRESH_DIV cycles so brightness stays uniform.
  - digit_en is sampled every cycle.
- Frame period: NUM_DIGITS*REFRESH_DIV cycles. frame_tick=1 in exactly the first cycle of digit 0's slot (cnt=0, idx=0), including the first cycle after reset release.
- Anti-tearing:
  - load writes shadow <= value and sets pending.
  - At the frame boundary edge (cnt=REFRESH_DIV-1, idx=NUM_DIGITS-1), if pending: disp_val <= shadow and pending clears.
  - Multiple loads within one frame: the last one wins.
  - load coinciding with the boundary edge: the new value goes to shadow with pending set, and is applied at the following boundary.
- Reset mid-slot or mid-frame: all state returns to reset values on that edge; pending and shadow are discarded.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: digit i (i>0) is blanked (anode bit held 1) when nibbles i..NUM_DIGITS-1 of disp_val are all zero. Digit 0 is always shown. Blanking is evaluated on disp_val, so it is stable within a frame.
- Undefined: all enabled digits display, including leading zeros. No extra logic is built.

Decomposition:
- Shared package/include holds:
  - SEG_BLANK = 7'b1111111
  - ANODE_OFF (all ones)
  - state encodings ST_BLANK and ST_DRIVE
- Natural sub-module: one instance of the existing hexToSevenSeg decoder, driven by the mux-selected nibble of disp_val. The decoder is never replicated per digit.

Test Plan:
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
1. Reset, then load value=16'h1234 and wait one frame boundary -> digit 0 slot: 2 cycles anode=4'b1111, then 6 cycles anode=4'b1110 with sevenSeg=7'b0011001; digit 1 slot shows sevenSeg=7'b0110000.
2. Free-run 3 frames -> frame_tick pulses exactly every 32 cycles; anode sequence per frame is 1110, 1101, 1011, 0111, each preceded by 2 blank cycles.
3. Load 16'hABCD at cnt=3 of digit 1's slot -> digits 1-3 still show 1234 values for the rest of the frame; ABCD appears from the next frame_tick.
4. digit_en=4'b0101 -> slots 1 and 3 keep anode=4'b1111 and sevenSeg=7'b1111111 for all 8 cycles; frame period stays 32.
5. Assert reset at cnt=5 of digit 2's slot -> next edge: anode=4'b1111, sevenSeg=7'b1111111, disp_val=0; after release, frame_tick fires on the first cycle and scanning restarts at digit 0.
6. value=16'h0040: with LEADING_ZERO_BLANK_EN, digits 3 and 2 dark, digit 1 shows 4 (7'b0011001), digit 0 shows 0 (7'b1000000); without the macro, all four digits lit, showing 0, 0, 4, 0.
